vector_stream_arbiter: RTL and testbench

- Packet-level round-robin arbiter that merges N_REQ vector streams (AXI-Stream style: valid/ready, data, index, last, keep) into one output stream.
- Used wherever several producers share one vector consumer, e.g. multiple compute lanes writing into one reduction or write-back unit.
- A grant holds from the first beat of a packet until its `last` beat is accepted, so packets are never interleaved.
- The output is registered: a one-entry pipeline stage with full throughput.

---
 rtl/vector_pkg.sv | 22 ++
 rtl/vector_stream_arbiter_rr_select.sv | 27 ++
 rtl/vector_stream_arbiter.sv | 134 +++++++++++++
 tb/tb_vector_stream_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// Shared width helpers and arbitration state type for the vector stream blocks.
package vector_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic int idx_width(input int vector_length, input int numbers);
    return $clog2(vector_length) * numbers;
  endfunction

  // $clog2(1) is 0, so clamp so that a zero-width bus never appears.
  function automatic int keep_width(input int numbers);
    return (numbers > 1) ? $clog2(numbers) : 1;
  endfunction

  function automatic int sel_width(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/vector_stream_arbiter_rr_select.sv
// Combinational round-robin picker: first asserted request strictly after ptr, with wrap.
module rr_select #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] gnt_id,
  output logic             gnt_any
);

  // Scan from the farthest offset down so the nearest hit after ptr wins.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (req[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/vector_stream_arbiter.sv
// Packet-level round-robin merge of N_REQ vector streams into one registered output stream.
module vector_stream_arbiter
  import vector_pkg::*;
#(
  parameter  int N_REQ         = 4,
  parameter  int NUMBERS       = 1,
  parameter  int NUMBER_WIDTH  = 32,
  parameter  int VECTOR_LENGTH = 32,
  localparam int DATA_WIDTH    = NUMBER_WIDTH * NUMBERS,
  localparam int INDEX_WIDTH   = idx_width(VECTOR_LENGTH, NUMBERS),
  localparam int KEEP_WIDTH    = keep_width(NUMBERS),
  localparam int SEL_WIDTH     = sel_width(N_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             s_valid,
  output logic [N_REQ-1:0]             s_ready,
  input  logic [N_REQ*DATA_WIDTH-1:0]  s_data,
  input  logic [N_REQ*INDEX_WIDTH-1:0] s_index,
  input  logic [N_REQ-1:0]             s_last,
  input  logic [N_REQ*KEEP_WIDTH-1:0]  s_keep,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic [INDEX_WIDTH-1:0]       m_index,
  output logic                         m_last,
  output logic [KEEP_WIDTH-1:0]        m_keep,
  output logic [SEL_WIDTH-1:0]         m_src
);

  arb_state_e             state_q, state_d;
  logic [SEL_WIDTH-1:0]   lock_id_q, lock_id_d;
  logic [SEL_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;

  logic                   m_valid_q;
  logic [DATA_WIDTH-1:0]  m_data_q;
  logic [INDEX_WIDTH-1:0] m_index_q;
  logic                   m_last_q;
  logic [KEEP_WIDTH-1:0]  m_keep_q;
  logic [SEL_WIDTH-1:0]   m_src_q;

  logic                   load_en;
  logic [SEL_WIDTH-1:0]   rr_id;
  logic                   rr_any;
  logic [SEL_WIDTH-1:0]   sel;
  logic                   grant_ok;
  logic                   xfer;
  logic                   sel_last;

  rr_select #(
    .N_REQ (N_REQ),
    .PTR_W (SEL_WIDTH)
  ) u_rr_select (
    .req     (s_valid),
    .ptr     (rr_ptr_q),
    .gnt_id  (rr_id),
    .gnt_any (rr_any)
  );

  assign load_en  = !m_valid_q || m_ready;
  assign sel      = (state_q == LOCKED) ? lock_id_q : rr_id;
  // While locked, ready is offered to the owner even if it is stalled; only IDLE gates on a request.
  assign grant_ok = load_en && ((state_q == IDLE) ? rr_any : 1'b1);
  assign xfer     = load_en && ((state_q == IDLE) ? rr_any : s_valid[lock_id_q]);
  assign sel_last = s_last[sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lock_id_q <= '0;
      rr_ptr_q  <= SEL_WIDTH'(N_REQ - 1);
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    rr_ptr_d  = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          lock_id_d = rr_id;
          if (!sel_last) state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (xfer && sel_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Fairness is per packet: the pointer only advances when a packet closes.
    if (xfer && sel_last) rr_ptr_d = sel;
  end

  always_comb begin
    s_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      s_ready[i] = grant_ok && (SEL_WIDTH'(i) == sel);
    end
  end

  // Output register stage: one-entry buffer, refilled in the same cycle it drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_index_q <= '0;
      m_last_q  <= 1'b0;
      m_keep_q  <= '0;
      m_src_q   <= '0;
    end else if (xfer) begin
      m_valid_q <= 1'b1;
      m_data_q  <= s_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
      m_index_q <= s_index[int'(sel)*INDEX_WIDTH +: INDEX_WIDTH];
      m_last_q  <= sel_last;
      m_keep_q  <= s_keep[int'(sel)*KEEP_WIDTH +: KEEP_WIDTH];
      m_src_q   <= sel;
    end else if (m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_index = m_index_q;
  assign m_last  = m_last_q;
  assign m_keep  = m_keep_q;
  assign m_src   = m_src_q;

endmodule

// File: tb/tb_vector_stream_arbiter.sv
// Directed bench for vector_stream_arbiter with hand-derived cycle-by-cycle expectations.
module tb_vector_stream_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 5;
  localparam int KW = 1;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    s_valid;
  logic [N-1:0]    s_ready;
  logic [N*DW-1:0] s_data;
  logic [N*IW-1:0] s_index;
  logic [N-1:0]    s_last;
  logic [N*KW-1:0] s_keep;
  logic            m_valid;
  logic            m_ready;
  logic [DW-1:0]   m_data;
  logic [IW-1:0]   m_index;
  logic            m_last;
  logic [KW-1:0]   m_keep;
  logic [SW-1:0]   m_src;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vector_stream_arbiter #(
    .N_REQ         (N),
    .NUMBERS       (1),
    .NUMBER_WIDTH  (DW),
    .VECTOR_LENGTH (32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_index (s_index),
    .s_last  (s_last),
    .s_keep  (s_keep),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_index (m_index),
    .m_last  (m_last),
    .m_keep  (m_keep),
    .m_src   (m_src)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drv(input int i, input logic v, input logic [31:0] d, input logic l);
    s_valid[i]         = v;
    s_data[i*DW +: DW] = d;
    s_index[i*IW +: IW] = d[4:0];
    s_last[i]          = l;
    s_keep[i]          = 1'b1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) drv(i, 1'b0, 32'h0, 1'b0);
  endtask

  // Advance to just after the next active edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] d, input logic [1:0] src, input logic l);
    check({tag, "_vld"}, m_valid, 1'b1);
    check({tag, "_data"}, m_data, d);
    check({tag, "_src"}, m_src, src);
    check({tag, "_last"}, m_last, l);
  endtask

  initial begin
    rst     = 1'b1;
    m_ready = 1'b1;
    s_valid = '0;
    s_data  = '0;
    s_index = '0;
    s_last  = '0;
    s_keep  = '0;
    cyc(); cyc();
    check("rst_mvalid", m_valid, 1'b0);
    check("rst_mdata", m_data, 32'h0);
    check("rst_msrc", m_src, 2'd0);
    check("rst_mlast", m_last, 1'b0);
    check("rst_sready", s_ready, 4'b0000);
    rst = 1'b0;

    // Single requester, 3-beat packet from req 2
    drv(2, 1'b1, 32'hA, 1'b0); #1;
    check("t1_rdy0", s_ready, 4'b0100);
    cyc();
    chk_beat("t1_b0", 32'hA, 2'd2, 1'b0);
    check("t1_index", m_index, 5'hA);
    check("t1_keep", m_keep, 1'b1);
    drv(2, 1'b1, 32'hB, 1'b0); #1;
    check("t1_rdy1", s_ready, 4'b0100);
    cyc();
    chk_beat("t1_b1", 32'hB, 2'd2, 1'b0);
    drv(2, 1'b1, 32'hC, 1'b1);
    cyc();
    chk_beat("t1_b2", 32'hC, 2'd2, 1'b1);
    idle_all();
    cyc();
    check("t1_drain", m_valid, 1'b0);

    // Contention from reset: 1-beat packets from everyone, strict rotation
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int i = 0; i < N; i++) drv(i, 1'b1, 32'h10 + i, 1'b1);
    for (int k = 0; k < 8; k++) begin
      logic [3:0] exp_rdy;
      #1;
      exp_rdy = 4'b0001 << (k % 4);
      check($sformatf("t2_rdy%0d", k), s_ready, exp_rdy);
      cyc();
      chk_beat($sformatf("t2_g%0d", k), 32'h10 + (k % 4), 2'(k % 4), 1'b1);
    end
    idle_all();
    cyc();
    check("t2_drain", m_valid, 1'b0);

    // Packet lock: req0 4 beats, req1 arrives mid-packet
    drv(0, 1'b1, 32'h20, 1'b0); #1;
    check("t3_rdy0", s_ready, 4'b0001);
    cyc();
    chk_beat("t3_b0", 32'h20, 2'd0, 1'b0);
    drv(0, 1'b1, 32'h21, 1'b0);
    drv(1, 1'b1, 32'h30, 1'b1); #1;
    check("t3_rdy1", s_ready, 4'b0001);
    cyc();
    chk_beat("t3_b1", 32'h21, 2'd0, 1'b0);
    drv(0, 1'b1, 32'h22, 1'b0); #1;
    check("t3_rdy2", s_ready, 4'b0001);
    cyc();
    chk_beat("t3_b2", 32'h22, 2'd0, 1'b0);
    drv(0, 1'b1, 32'h23, 1'b1); #1;
    check("t3_rdy3", s_ready, 4'b0001);
    cyc();
    chk_beat("t3_b3", 32'h23, 2'd0, 1'b1);
    drv(0, 1'b0, 32'h0, 1'b0); #1;
    check("t3_rdy_r1", s_ready, 4'b0010);
    cyc();
    chk_beat("t3_r1", 32'h30, 2'd1, 1'b1);
    idle_all();
    cyc();
    check("t3_drain", m_valid, 1'b0);

    // Backpressure mid-packet on req2
    drv(2, 1'b1, 32'h40, 1'b0);
    cyc();
    chk_beat("t4_b0", 32'h40, 2'd2, 1'b0);
    drv(2, 1'b1, 32'h41, 1'b0);
    cyc();
    chk_beat("t4_b1", 32'h41, 2'd2, 1'b0);
    drv(2, 1'b1, 32'h42, 1'b0);
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("t4_stall_rdy%0d", k), s_ready, 4'b0000);
      cyc();
      chk_beat($sformatf("t4_hold%0d", k), 32'h41, 2'd2, 1'b0);
    end
    m_ready = 1'b1; #1;
    check("t4_release_rdy", s_ready, 4'b0100);
    cyc();
    chk_beat("t4_b2", 32'h42, 2'd2, 1'b0);
    drv(2, 1'b1, 32'h43, 1'b1);
    cyc();
    chk_beat("t4_b3", 32'h43, 2'd2, 1'b1);
    idle_all();
    cyc();
    check("t4_drain", m_valid, 1'b0);

    // Source stall: req3 locked, req0 waiting
    drv(3, 1'b1, 32'h50, 1'b0);
    drv(0, 1'b1, 32'h60, 1'b1); #1;
    check("t5_rdy0", s_ready, 4'b1000);
    cyc();
    chk_beat("t5_b0", 32'h50, 2'd3, 1'b0);
    drv(3, 1'b0, 32'h0, 1'b0); #1;
    check("t5_stall_rdy", s_ready, 4'b1000);
    cyc();
    check("t5_bubble0", m_valid, 1'b0);
    cyc();
    check("t5_bubble1", m_valid, 1'b0);
    drv(3, 1'b1, 32'h51, 1'b1);
    cyc();
    chk_beat("t5_b1", 32'h51, 2'd3, 1'b1);
    drv(3, 1'b0, 32'h0, 1'b0); #1;
    check("t5_rdy_r0", s_ready, 4'b0001);
    cyc();
    chk_beat("t5_r0", 32'h60, 2'd0, 1'b1);
    idle_all();
    cyc();
    check("t5_drain", m_valid, 1'b0);

    // Reset in the middle of req1's packet
    drv(1, 1'b1, 32'h70, 1'b0);
    cyc();
    chk_beat("t6_b0", 32'h70, 2'd1, 1'b0);
    drv(1, 1'b1, 32'h71, 1'b0);
    rst = 1'b1;
    cyc();
    check("t6_rst_mvalid", m_valid, 1'b0);
    check("t6_rst_mdata", m_data, 32'h0);
    rst = 1'b0;
    drv(1, 1'b1, 32'h80, 1'b1);
    drv(0, 1'b1, 32'h90, 1'b1); #1;
    check("t6_rdy0", s_ready, 4'b0001);
    cyc();
    chk_beat("t6_g0", 32'h90, 2'd0, 1'b1);
    drv(0, 1'b0, 32'h0, 1'b0); #1;
    check("t6_rdy1", s_ready, 4'b0010);
    cyc();
    chk_beat("t6_g1", 32'h80, 2'd1, 1'b1);
    idle_all();
    cyc();
    check("t6_drain", m_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
